// File: rtl/booth_r8_seq_decoder.sv
// Sequential radix-8 Booth digit consumer: one digit group per cycle,
// accumulating sign*mag*mcand<<(3*g) into an exact unsigned product.
module booth_r8_seq_decoder #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned GROUPS = (WIDTH >> 2) + 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      mcand,
    input  logic [GROUPS-1:0]     s,
    input  logic [GROUPS-1:0]     d,
    input  logic [GROUPS-1:0]     t,
    input  logic [GROUPS-1:0]     q,
    input  logic [GROUPS-1:0]     n,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [2*WIDTH-1:0]    product,
    output logic                  err
);

    localparam int unsigned AW = 2 * WIDTH + 4;
    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned GW = (GROUPS > 1) ? $clog2(GROUPS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [GW-1:0]     r_g;
    logic [AW-1:0]     r_m1;
    logic [AW-1:0]     r_m3;
    logic [AW-1:0]     r_acc;
    logic [GROUPS-1:0] r_s;
    logic [GROUPS-1:0] r_d;
    logic [GROUPS-1:0] r_t;
    logic [GROUPS-1:0] r_q;
    logic [GROUPS-1:0] r_n;
    logic [PW-1:0]     r_product;
    logic              r_out_valid;
    logic              r_in_ready;
    logic              r_err;

    logic              w_last;
    logic              w_multi;
    logic [AW-1:0]     w_term;
    logic [AW-1:0]     w_acc_next;

    assign w_last = (r_g == GW'(GROUPS - 1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (in_valid)  w_state_next = ST_RUN;
            ST_RUN:  if (w_last)    w_state_next = ST_DONE;
            ST_DONE: if (out_ready) w_state_next = ST_IDLE;
            default:                w_state_next = ST_IDLE;
        endcase
    end

    // Digit decode of the current group (always bit 0 of the shifting digit registers).
    // r_m1/r_m3 are pre-shifted by 3*g, so no variable shifter is needed.
    always_comb begin
        w_term  = '0;
        w_multi = (r_s[0] & r_d[0]) | (r_s[0] & r_t[0]) | (r_s[0] & r_q[0]) |
                  (r_d[0] & r_t[0]) | (r_d[0] & r_q[0]) | (r_t[0] & r_q[0]);
        case ({r_q[0], r_t[0], r_d[0], r_s[0]})
            4'b0001: w_term = r_m1;
            4'b0010: w_term = r_m1 << 1;
            4'b0100: w_term = r_m3;
            4'b1000: w_term = r_m1 << 2;
            default: w_term = '0;
        endcase
        // Direct subtract: a zero-magnitude negated digit contributes exactly 0
        w_acc_next = r_n[0] ? (r_acc - w_term) : (r_acc + w_term);
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_g         <= '0;
            r_m1        <= '0;
            r_m3        <= '0;
            r_acc       <= '0;
            r_s         <= '0;
            r_d         <= '0;
            r_t         <= '0;
            r_q         <= '0;
            r_n         <= '0;
            r_product   <= '0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_m1       <= AW'(mcand);
                        r_m3       <= (AW'(mcand) << 1) + AW'(mcand);
                        r_s        <= s;
                        r_d        <= d;
                        r_t        <= t;
                        r_q        <= q;
                        r_n        <= n;
                        r_acc      <= '0;
                        r_g        <= '0;
                        r_err      <= 1'b0;
                        r_in_ready <= 1'b0;
                    end
                end
                ST_RUN: begin
                    r_acc <= w_acc_next;
                    r_g   <= r_g + GW'(1);
                    r_m1  <= r_m1 << 3;
                    r_m3  <= r_m3 << 3;
                    r_s   <= r_s >> 1;
                    r_d   <= r_d >> 1;
                    r_t   <= r_t >> 1;
                    r_q   <= r_q >> 1;
                    r_n   <= r_n >> 1;
                    r_err <= r_err | w_multi;
                    if (w_last) begin
                        r_product   <= w_acc_next[PW-1:0];
                        r_out_valid <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign product   = r_product;
    assign err       = r_err;

endmodule

// File: tb/tb_booth_r8_seq_decoder.sv
// Directed self-checking bench for booth_r8_seq_decoder (WIDTH=32, GROUPS=11).
module tb_booth_r8_seq_decoder;

    localparam int unsigned W = 32;
    localparam int unsigned G = 11;

    logic           clk;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   mcand;
    logic [G-1:0]   s, d, t, q, n;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] product;
    logic           err;

    int n_checks = 0;
    int n_fail   = 0;

    booth_r8_seq_decoder #(.WIDTH(W), .GROUPS(G)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mcand     (mcand),
        .s         (s),
        .d         (d),
        .t         (t),
        .q         (q),
        .n         (n),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Upstream radix-8 encoder model: digit = -4*y[3g+2] + 2*y[3g+1] + y[3g] + y[3g-1]
    task automatic booth_enc(input logic [31:0] y,
                             output logic [G-1:0] vs, output logic [G-1:0] vd,
                             output logic [G-1:0] vt, output logic [G-1:0] vq,
                             output logic [G-1:0] vn);
        logic [35:0] ye;
        logic [3:0]  b;
        int          dg;
        ye = {3'b000, y, 1'b0};
        vs = '0; vd = '0; vt = '0; vq = '0; vn = '0;
        for (int g = 0; g < int'(G); g++) begin
            b  = ye[3*g +: 4];
            dg = (b[3] ? -4 : 0) + (b[2] ? 2 : 0) + (b[1] ? 1 : 0) + (b[0] ? 1 : 0);
            vn[g] = b[3];
            if (dg < 0) dg = -dg;
            case (dg)
                1: vs[g] = 1'b1;
                2: vd[g] = 1'b1;
                3: vt[g] = 1'b1;
                4: vq[g] = 1'b1;
                default: ;
            endcase
        end
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] mc,
                          input logic [G-1:0] vs, input logic [G-1:0] vd,
                          input logic [G-1:0] vt, input logic [G-1:0] vq,
                          input logic [G-1:0] vn,
                          input logic [63:0] exp_p, input logic exp_e, input int hold);
        int cnt;
        @(negedge clk);
        check({tag, ":in_ready_idle"}, 64'(in_ready), 64'd1);
        mcand = mc; s = vs; d = vd; t = vt; q = vq; n = vn;
        in_valid = 1'b1;
        @(negedge clk);
        // Scramble inputs while busy; they must be ignored
        in_valid = 1'b0;
        mcand = $urandom;
        s = G'($urandom); d = G'($urandom); t = G'($urandom);
        q = G'($urandom); n = G'($urandom);
        cnt = 0;
        while (!out_valid && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        check({tag, ":latency"}, 64'(cnt), 64'(G));
        check({tag, ":product"}, product, exp_p);
        check({tag, ":err"}, 64'(err), 64'(exp_e));
        if (hold > 0) begin
            in_valid = 1'b1;
            for (int i = 0; i < hold; i++) begin
                check({tag, ":hold_valid"}, 64'(out_valid), 64'd1);
                check({tag, ":hold_product"}, product, exp_p);
                check({tag, ":hold_in_ready"}, 64'(in_ready), 64'd0);
                @(negedge clk);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, ":valid_drop"}, 64'(out_valid), 64'd0);
        check({tag, ":in_ready_rise"}, 64'(in_ready), 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic run_mul(input string tag, input logic [W-1:0] mc, input logic [31:0] y,
                           input logic [63:0] exp_p, input int hold);
        logic [G-1:0] vs, vd, vt, vq, vn;
        booth_enc(y, vs, vd, vt, vq, vn);
        run_op(tag, mc, vs, vd, vt, vq, vn, exp_p, 1'b0, hold);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [G-1:0] vs, vd, vt, vq, vn;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; mcand = '0;
        s = '0; d = '0; t = '0; q = '0; n = '0;
        repeat (2) @(negedge clk);
        check("reset:in_ready", 64'(in_ready), 64'd1);
        check("reset:out_valid", 64'(out_valid), 64'd0);
        check("reset:product", product, 64'd0);
        check("reset:err", 64'(err), 64'd0);
        rst_n = 1'b1;

        // 7 = 8 - 1: g0 = -1, g1 = +1
        run_op("m5x7", 32'd5, 11'b00000000011, '0, '0, '0, 11'b00000000001,
               64'd35, 1'b0, 0);
        run_mul("max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 0);
        run_op("zero_neg", 32'h1234, '0, '0, '0, '0, 11'h7FF, 64'd0, 1'b0, 0);
        run_op("t_plus_zneg", 32'h1234, '0, '0, 11'b00000000001, '0, 11'h7FE,
               64'h369C, 1'b0, 0);
        run_mul("hold", 32'hFFFF_FFFF, 32'd2, 64'h1_FFFF_FFFE, 20);
        // g0 = +1, g3 multi-hot s+d contributes nothing and flags err
        run_op("multihot", 32'd100, 11'b00000001001, 11'b00000001000, '0, '0, '0,
               64'd100, 1'b1, 0);
        run_mul("after_err", 32'd3, 32'd4, 64'd12, 0);
        run_mul("k1000", 32'd1000, 32'd1000, 64'hF4240, 0);
        run_mul("msb", 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 0);

        // Reset in the middle of RUN at group 5
        booth_enc(32'd123, vs, vd, vt, vq, vn);
        @(negedge clk);
        mcand = 32'h777; s = vs; d = vd; t = vt; q = vq; n = vn;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst:in_ready", 64'(in_ready), 64'd1);
        check("midrst:out_valid", 64'(out_valid), 64'd0);
        check("midrst:product", product, 64'd0);
        check("midrst:err", 64'(err), 64'd0);
        @(negedge clk);
        check("midrst:held_valid", 64'(out_valid), 64'd0);
        rst_n = 1'b1;
        run_mul("post_rst", 32'h777, 32'd123, 64'h3962D, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
